// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master and the SPI slave + RAM subsystem:
// frame geometry, command encodings and the master's state enum.
package spi_pkg;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT,
    ST_GAP,
    ST_RECV,
    ST_END
  } spi_state_e;

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load, MSB-out shift register with serial-in capture. The same
// register serialises the outgoing frame and collects the incoming reply.
// It exposes its *next* contents so the owner can register outputs from it.
module spi_shift_reg
  import spi_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_data,
  input  logic               shift_en,
  input  logic               serial_in,
  output logic               msb_next,
  output logic [DATA_W-1:0]  capture_next
);

  logic [FRAME_W-1:0] data_d;
  logic [FRAME_W-1:0] data_q;

  // Load wins over shift; otherwise shift left, pulling serial_in into bit 0.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_data;
    end else if (shift_en) begin
      data_d = {data_q[FRAME_W-2:0], serial_in};
    end
  end

  assign msb_next     = data_d[FRAME_W-1];
  assign capture_next = data_d[DATA_W-1:0];

  // Register update with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master controller: sends one 10-bit {cmd, wdata} frame per host request
// and, for read-data commands, captures the 8-bit reply from MISO. All outputs
// are flops loaded from the next-state decode, so they line up with the state.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int LEAD_CYCLES = 2,
  parameter int GAP_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        cmd,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  // Counter reload values: each state counts down to zero on its last cycle.
  localparam logic [3:0] LEAD_LOAD  = 4'(LEAD_CYCLES - 1);
  localparam logic [3:0] SHIFT_LOAD = 4'(FRAME_W - 1);
  localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES - 1);
  localparam logic [3:0] RECV_LOAD  = 4'(DATA_W - 1);

  spi_state_e        state_d, state_q;
  logic [3:0]        cnt_d, cnt_q;
  logic              rd_cmd_d, rd_cmd_q;
  logic              ss_n_d, ss_n_q;
  logic              mosi_d, mosi_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;
  logic              rvalid_d, rvalid_q;
  logic [DATA_W-1:0] rdata_d, rdata_q;

  logic              sr_load;
  logic              sr_shift;
  logic              sr_msb_next;
  logic [DATA_W-1:0] sr_capture_next;

  spi_shift_reg u_shift_reg (
    .clk          (clk),
    .rst          (rst),
    .load         (sr_load),
    .load_data    ({cmd, wdata}),
    .shift_en     (sr_shift),
    .serial_in    (MISO),
    .msb_next     (sr_msb_next),
    .capture_next (sr_capture_next)
  );

  // Next-state, counter and shift control, then the next output values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_cmd_d = rd_cmd_q;
    sr_load  = 1'b0;
    sr_shift = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_LEAD;
          cnt_d    = LEAD_LOAD;
          rd_cmd_d = (cmd == CMD_RD_DATA);
          sr_load  = 1'b1;
        end
      end
      ST_LEAD: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_SHIFT;
          cnt_d   = SHIFT_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_SHIFT: begin
        sr_shift = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = rd_cmd_q ? ST_GAP : ST_END;
          cnt_d   = rd_cmd_q ? GAP_LOAD : 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RECV;
          cnt_d   = RECV_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RECV: begin
        sr_shift = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = ST_END;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_END: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    ss_n_d   = !(state_d inside {ST_LEAD, ST_SHIFT, ST_GAP, ST_RECV});
    mosi_d   = (state_d inside {ST_LEAD, ST_SHIFT}) ? sr_msb_next : 1'b0;
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_END);
    rvalid_d = (state_d == ST_END) && rd_cmd_q;
    rdata_d  = rvalid_d ? sr_capture_next : rdata_q;
  end

  // State, counter and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      rd_cmd_q <= 1'b0;
      ss_n_q   <= 1'b1;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_cmd_q <= rd_cmd_d;
      ss_n_q   <= ss_n_d;
      mosi_q   <= mosi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign SS_n   = ss_n_q;
  assign MOSI   = mosi_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Testbench for spi_master_ctrl: a behavioural SPI slave + RAM decodes the
// MOSI frames and drives MISO replies; expected frames and completions are
// queued when a request is issued and popped by a negedge monitor.
module tb_spi_master_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       rvalid;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  spi_master_ctrl #(.LEAD_CYCLES(2), .GAP_CYCLES(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cmd    (cmd),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .rdata  (rdata),
    .rvalid (rvalid),
    .SS_n   (SS_n),
    .MOSI   (MOSI),
    .MISO   (MISO)
  );

  // 100 MHz system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rv;
    logic [7:0] rd;
    int         lowLen;
  } doneExp_t;

  logic [9:0] frameQ[$];
  doneExp_t   doneQ[$];

  int testsRun  = 0;
  int failCount = 0;

  logic [7:0] modelRdata = 8'h00;

  // Slave model state.
  int          lowCnt   = 0;
  int          hiCnt    = 0;
  int          lastLow  = 0;
  int          lastHigh = 0;
  logic [11:0] mosiBits = '0;
  logic [7:0]  slaveAddr = 8'h00;
  logic [7:0]  ram [0:255];
  logic [7:0]  reply = 8'h00;
  logic        overrideEn = 1'b0;
  logic [7:0]  overrideVal = 8'h00;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Slave + RAM model and the scoreboard monitor share one negedge process so
  // the low/high run counters they both rely on are updated before use.
  always @(negedge clk) begin
    if (SS_n == 1'b0) begin
      if (lowCnt == 0) begin
        lastHigh = hiCnt;
      end
      hiCnt    = 0;
      lowCnt   = lowCnt + 1;
      mosiBits = {mosiBits[10:0], MOSI};
      if (lowCnt == 12) begin
        if (frameQ.size() == 0) begin
          checkOutput("frame_expected", frameQ.size(), 1);
        end else begin
          logic [9:0] f;
          f = frameQ.pop_front();
          checkOutput("mosi_frame", mosiBits, {f[9], f[9], f});
        end
        case (mosiBits[9:8])
          2'b00: slaveAddr = mosiBits[7:0];
          2'b01: ram[slaveAddr] = mosiBits[7:0];
          2'b10: slaveAddr = mosiBits[7:0];
          default: reply = overrideEn ? overrideVal : ram[slaveAddr];
        endcase
      end
      MISO = (lowCnt >= 15 && lowCnt <= 22) ? reply[22 - lowCnt] : 1'b0;
    end else begin
      if (lowCnt != 0) begin
        lastLow = lowCnt;
      end
      lowCnt = 0;
      hiCnt  = hiCnt + 1;
      MISO   = 1'b0;
    end

    if (done === 1'b1) begin
      if (doneQ.size() == 0) begin
        checkOutput("done_expected", doneQ.size(), 1);
      end else begin
        doneExp_t e;
        e = doneQ.pop_front();
        checkOutput("done_rvalid_rdata", {SS_n, rvalid, rdata}, {1'b1, e.rv, e.rd});
        checkOutput("ss_n_low_cycles", lastLow, e.lowLen);
      end
    end
  end

  // Queue the expected frame and completion for one request.
  task automatic pushExpected(input logic [1:0] c, input logic [7:0] w,
                              input logic [7:0] expRd);
    doneExp_t e;
    frameQ.push_back({c, w});
    if (c == 2'b11) begin
      modelRdata = expRd;
    end
    e.rv     = (c == 2'b11);
    e.rd     = modelRdata;
    e.lowLen = (c == 2'b11) ? 22 : 12;
    doneQ.push_back(e);
  endtask

  // Issue one request once the master is idle; scramble inputs after acceptance.
  task automatic applyStimulus(input logic [1:0] c, input logic [7:0] w,
                               input logic [7:0] expRd);
    for (int i = 0; i < 50 && busy !== 1'b0; i++) begin
      @(posedge clk); #1;
    end
    pushExpected(c, w, expRd);
    start = 1'b1;
    cmd   = c;
    wdata = w;
    @(posedge clk); #1;
    start = 1'b0;
    cmd   = ~c;
    wdata = ~w;
  endtask

  task automatic waitDone();
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) return;
    end
    checkOutput("done_timeout", done, 1);
  endtask

  // Wait until the current cycle is SS_n low-cycle number target+1.
  task automatic waitLowCount(input int target);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (lowCnt == target) return;
    end
    checkOutput("low_count_timeout", lowCnt, target);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    rst   = 1'b1;
    start = 1'b0;
    cmd   = 2'b00;
    wdata = 8'h00;
    MISO  = 1'b0;

    // Reset held for 5 cycles: outputs at reset values throughout.
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("reset_outputs", {SS_n, MOSI, busy, done, rvalid, rdata},
                  {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Write address 3, write 0x55, read it back through the slave RAM.
    applyStimulus(2'b00, 8'h03, 8'h00); waitDone();
    applyStimulus(2'b01, 8'h55, 8'h00); waitDone();
    applyStimulus(2'b10, 8'h03, 8'h00); waitDone();
    applyStimulus(2'b11, 8'h00, 8'h55); waitDone();

    // Same read with the MISO model forced to 0xA5.
    overrideEn  = 1'b1;
    overrideVal = 8'hA5;
    applyStimulus(2'b11, 8'h00, 8'hA5); waitDone();
    overrideEn  = 1'b0;

    // Start pulsed during SHIFT is ignored: one frame, one done.
    applyStimulus(2'b00, 8'h05, 8'h00);
    waitLowCount(6);
    start = 1'b1;
    cmd   = 2'b00;
    wdata = 8'h3C;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone();
    repeat (30) @(posedge clk);
    #1;
    checkOutput("no_second_frame", {busy, SS_n}, {1'b0, 1'b1});

    // Reset at the 5th SHIFT bit aborts the frame with no done.
    start = 1'b1;
    cmd   = 2'b00;
    wdata = 8'h07;
    @(posedge clk); #1;
    start = 1'b0;
    waitLowCount(6);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    modelRdata = 8'h00;
    checkOutput("rst_mid_frame", {SS_n, MOSI, busy, done, rvalid, rdata},
                {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    @(posedge clk); #1;
    checkOutput("rst_mid_frame_idle", {SS_n, busy, done}, {1'b1, 1'b0, 1'b0});

    // Traffic after the abort completes normally (slave address still 5).
    applyStimulus(2'b01, 8'h66, 8'h00); waitDone();
    applyStimulus(2'b10, 8'h05, 8'h00); waitDone();
    applyStimulus(2'b11, 8'h00, 8'h66); waitDone();

    // Back-to-back frames with start held high: SS_n high exactly 2 cycles.
    pushExpected(2'b00, 8'h09, 8'h00);
    pushExpected(2'b00, 8'h09, 8'h00);
    start = 1'b1;
    cmd   = 2'b00;
    wdata = 8'h09;
    @(posedge clk); #1;
    waitDone();
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone();
    checkOutput("b2b_gap", lastHigh, 2);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("frames_left", frameQ.size(), 0);
    checkOutput("dones_left", doneQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
